// File: rtl/prbs_tx_pkg.sv
// prbs_tx_pkg: shared PRBS definitions for the transmitter and the matching receiver.
// Contents: polynomial selector encoding, FSM state codes, next-bit tap function,
// and sequence period per polynomial.
package prbs_tx_pkg;

  // Polynomial selector values carried by the PRBS_TYPE parameter.
  typedef enum logic [2:0] {
    PRBS3  = 3'd0,
    PRBS7  = 3'd1,
    PRBS9  = 3'd2,
    PRBS11 = 3'd3,
    PRBS15 = 3'd4,
    PRBS17 = 3'd5,
    PRBS23 = 3'd6,
    PRBS32 = 3'd7
  } prbs_type_e;

  // Transmit FSM state codes.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STOP = 2'd2;

  // Next sequence bit from the history register; h[0] is the most recent bit.
  function automatic logic prbs_next(input logic [31:0] h, input int unsigned t);
    logic b;
    case (prbs_type_e'(t[2:0]))
      PRBS3:   b = h[2]  ^ h[0];
      PRBS7:   b = h[6]  ^ h[0];
      PRBS9:   b = h[8]  ^ h[4];
      PRBS11:  b = h[10] ^ h[8];
      PRBS15:  b = h[14] ^ h[0];
      PRBS17:  b = h[16] ^ h[2];
      PRBS23:  b = h[22] ^ h[17];
      default: b = h[31] ^ h[21] ^ h[1] ^ h[0];
    endcase
    return b;
  endfunction

  // Number of bits in one full period of the selected sequence.
  function automatic logic [31:0] prbs_period(input int unsigned t);
    logic [31:0] p;
    case (prbs_type_e'(t[2:0]))
      PRBS3:   p = 32'd7;
      PRBS7:   p = 32'd127;
      PRBS9:   p = 32'd511;
      PRBS11:  p = 32'd2047;
      PRBS15:  p = 32'd32767;
      PRBS17:  p = 32'd131071;
      PRBS23:  p = 32'd8388607;
      default: p = 32'hFFFF_FFFF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/prbs_tx_if.sv
// prbs_tx_if: control, serial data and status bundle of the PRBS transmitter.
//   en, restart, err_inj, dout_rdy : controls into the transmitter
//   dout_vld, dout                 : serial bit and its valid
//   seq_cnt, seq_wrap              : position in period, period-complete pulse
//   inj_cnt                        : saturating count of injected errors
// master = transmitter side, slave = controller/consumer side.
interface prbs_tx_if;
  logic        en;
  logic        restart;
  logic        err_inj;
  logic        dout_rdy;
  logic        dout_vld;
  logic        dout;
  logic [31:0] seq_cnt;
  logic        seq_wrap;
  logic [15:0] inj_cnt;

  modport master (
    input  en, restart, err_inj, dout_rdy,
    output dout_vld, dout, seq_cnt, seq_wrap, inj_cnt
  );

  modport slave (
    output en, restart, err_inj, dout_rdy,
    input  dout_vld, dout, seq_cnt, seq_wrap, inj_cnt
  );
endinterface

// File: rtl/prbs_taps.sv
// prbs_taps: combinational next-bit generator for the selected PRBS polynomial.
//   i_hist : 32-bit history, i_hist[0] most recent bit
//   o_bit  : XOR of the selected tap bits
module prbs_taps
  import prbs_tx_pkg::*;
#(
  parameter int unsigned PRBS_TYPE = 7
) (
  input  logic [31:0] i_hist,
  output logic        o_bit
);

  assign o_bit = prbs_next(i_hist, PRBS_TYPE);

endmodule

// File: rtl/prbs_tx.sv
// prbs_tx: serial PRBS transmitter with ready/valid output, restart and error injection.
//   clk, rst : clock, synchronous active-high reset
//   bus      : prbs_tx_if.master (controls in; dout/dout_vld, seq_cnt, seq_wrap, inj_cnt out)
// The history register advances only on an accepted bit, so stalls and idle
// periods never skip or repeat sequence bits.
module prbs_tx
  import prbs_tx_pkg::*;
#(
  parameter int unsigned PRBS_TYPE = 7,
  parameter logic [31:0] SEED      = 32'hFFFF_FFFF
) (
  input  logic      clk,
  input  logic      rst,
  prbs_tx_if.master bus
);

  localparam logic [31:0] P_LAST = prbs_period(PRBS_TYPE) - 32'd1;

  logic [1:0]  r_state;
  logic [31:0] r_hist;
  logic [31:0] r_seq_cnt;
  logic        r_inj_pend;
  logic [15:0] r_inj_cnt;
  logic        r_seq_wrap;

  logic        w_tap_bit;
  logic        w_vld;
  logic        w_acc;
  logic        w_last;
  logic        w_inj_take;

  prbs_taps #(.PRBS_TYPE(PRBS_TYPE)) u_taps (
    .i_hist (r_hist),
    .o_bit  (w_tap_bit)
  );

  assign w_vld      = (r_state != ST_IDLE);
  // restart discards a coincident handshake entirely, including its FSM effect
  assign w_acc      = w_vld & bus.dout_rdy & ~bus.restart;
  assign w_last     = (r_seq_cnt == P_LAST);
  assign w_inj_take = bus.err_inj & ~r_inj_pend & ~bus.restart;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_hist     <= SEED;
      r_seq_cnt  <= '0;
      r_inj_pend <= 1'b0;
      r_inj_cnt  <= '0;
      r_seq_wrap <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.en) r_state <= ST_RUN;
        ST_RUN:  if (!bus.en) r_state <= ST_STOP;
        ST_STOP: begin
          if (bus.en)     r_state <= ST_RUN;
          else if (w_acc) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase

      if (bus.restart) begin
        r_hist     <= SEED;
        r_seq_cnt  <= '0;
        r_inj_pend <= 1'b0;
        r_seq_wrap <= 1'b0;
      end else begin
        r_seq_wrap <= w_acc & w_last;
        if (w_acc) begin
          // history always takes the uninverted bit so injection never corrupts the sequence
          r_hist    <= {r_hist[30:0], w_tap_bit};
          r_seq_cnt <= w_last ? '0 : r_seq_cnt + 32'd1;
        end
        // a request arriving with the accepting handshake targets the following bit
        if (w_inj_take)  r_inj_pend <= 1'b1;
        else if (w_acc)  r_inj_pend <= 1'b0;
      end

      if (w_inj_take && (r_inj_cnt != '1)) r_inj_cnt <= r_inj_cnt + 16'd1;
    end
  end

  assign bus.dout_vld = w_vld;
  assign bus.dout     = w_vld & (w_tap_bit ^ r_inj_pend);
  assign bus.seq_cnt  = r_seq_cnt;
  assign bus.seq_wrap = r_seq_wrap;
  assign bus.inj_cnt  = r_inj_cnt;

endmodule

// File: tb/tb_prbs_tx.sv
// tb_prbs_tx: directed self-checking bench for prbs_tx.
// Three instances: PRBS3 (seed 7), PRBS7 (default seed), PRBS32 (looped into a
// bench-side receiver that locks on 32 bits and then free-runs its own LFSR).
module tb_prbs_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prbs_tx_if u0_if ();
  prbs_tx_if u1_if ();
  prbs_tx_if u7_if ();

  prbs_tx #(.PRBS_TYPE(0), .SEED(32'h7)) u_dut0 (.clk(clk), .rst(rst), .bus(u0_if));
  prbs_tx #(.PRBS_TYPE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(u1_if));
  prbs_tx #(.PRBS_TYPE(7), .SEED(32'hFFFF_FFFF)) u_dut7 (.clk(clk), .rst(rst), .bus(u7_if));

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;

  logic [6:0]  m1;     // PRBS7 reference: x^7 + x^6 + 1 style, next = m[6]^m[0]
  int unsigned acc1;   // accepted bits on u1 since last restart

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle on u1: check presented bit against the model, then drive rdy/err_inj.
  task automatic u1_cycle(input logic rdy, input logic inj, input logic inv);
    logic eb;
    eb = m1[6] ^ m1[0];
    check("u1_vld", {31'd0, u1_if.dout_vld}, 32'd1);
    check("u1_dout", {31'd0, u1_if.dout}, {31'd0, eb ^ inv});
    check("u1_cnt", u1_if.seq_cnt, acc1);
    u1_if.dout_rdy = rdy;
    u1_if.err_inj  = inj;
    tick();
    u1_if.err_inj  = 1'b0;
    if (rdy) begin
      m1 = {m1[5:0], eb};
      acc1++;
    end
  endtask

  initial begin
    logic [6:0]  exp0;
    logic        r;
    logic        prev_stall;
    logic        prev_dout;
    logic [31:0] rx_sh;
    int unsigned rx_n;
    int unsigned rx_err;
    logic        b;
    logic        pred;

    exp0 = 7'b1110010;  // bits 0..6 = 0,1,0,0,1,1,1
    rst = 1'b1;
    u0_if.en = 0; u0_if.restart = 0; u0_if.err_inj = 0; u0_if.dout_rdy = 0;
    u1_if.en = 0; u1_if.restart = 0; u1_if.err_inj = 0; u1_if.dout_rdy = 0;
    u7_if.en = 0; u7_if.restart = 0; u7_if.err_inj = 0; u7_if.dout_rdy = 0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_vld", {31'd0, u1_if.dout_vld}, 32'd0);
    check("rst_dout", {31'd0, u1_if.dout}, 32'd0);
    check("rst_cnt", u1_if.seq_cnt, 32'd0);
    check("rst_inj", {16'd0, u1_if.inj_cnt}, 32'd0);
    check("rst_wrap", {31'd0, u1_if.seq_wrap}, 32'd0);
    tick();
    check("idle_vld", {31'd0, u0_if.dout_vld}, 32'd0);

    // PRBS3 stream and period wrap
    u0_if.en = 1'b1;
    u0_if.dout_rdy = 1'b1;
    tick();
    for (int i = 0; i < 21; i++) begin
      check("p3_dout", {31'd0, u0_if.dout}, {31'd0, exp0[i % 7]});
      check("p3_cnt", u0_if.seq_cnt, i % 7);
      check("p3_wrap", {31'd0, u0_if.seq_wrap}, ((i > 0) && (i % 7 == 0)) ? 32'd1 : 32'd0);
      tick();
    end
    u0_if.en = 1'b0;

    // PRBS7 with random ready: accepted stream equals the free-running model
    m1 = 7'h7F;
    acc1 = 0;
    u1_if.en = 1'b1;
    tick();
    prev_stall = 1'b0;
    prev_dout  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      r = 1'($urandom_range(0, 1));
      if (prev_stall) check("b_stable", {31'd0, u1_if.dout}, {31'd0, prev_dout});
      prev_dout  = u1_if.dout;
      prev_stall = ~r;
      u1_cycle(r, 1'b0, 1'b0);
    end

    // Restart alone (no handshake)
    u1_if.dout_rdy = 1'b0;
    u1_if.restart  = 1'b1;
    tick();
    u1_if.restart  = 1'b0;
    m1 = 7'h7F;
    acc1 = 0;
    check("rs_cnt", u1_if.seq_cnt, 32'd0);

    // Error injection at accepted bit 10
    while (acc1 < 10) u1_cycle(1'b1, 1'b0, 1'b0);
    u1_cycle(1'b0, 1'b1, 1'b0);
    check("inj_cnt1", {16'd0, u1_if.inj_cnt}, 32'd1);
    u1_cycle(1'b0, 1'b1, 1'b1);
    check("inj_cnt_pend", {16'd0, u1_if.inj_cnt}, 32'd1);
    u1_cycle(1'b1, 1'b0, 1'b1);
    repeat (5) u1_cycle(1'b1, 1'b0, 1'b0);
    check("inj_cnt_end", {16'd0, u1_if.inj_cnt}, 32'd1);

    // en dropped while stalled, then resume
    u1_if.dout_rdy = 1'b0;
    u1_if.en = 1'b0;
    tick();
    check("stop_vld", {31'd0, u1_if.dout_vld}, 32'd1);
    check("stop_hold", {31'd0, u1_if.dout}, {31'd0, m1[6] ^ m1[0]});
    tick();
    check("stop_vld2", {31'd0, u1_if.dout_vld}, 32'd1);
    u1_if.dout_rdy = 1'b1;
    tick();
    m1 = {m1[5:0], m1[6] ^ m1[0]};
    acc1++;
    check("idle_vld2", {31'd0, u1_if.dout_vld}, 32'd0);
    check("idle_dout", {31'd0, u1_if.dout}, 32'd0);
    tick();
    tick();
    check("idle_cnt", u1_if.seq_cnt, acc1);
    u1_if.en = 1'b1;
    tick();
    repeat (4) u1_cycle(1'b1, 1'b0, 1'b0);

    // Restart coincident with handshake at seq_cnt=5
    u1_if.dout_rdy = 1'b0;
    u1_if.restart  = 1'b1;
    tick();
    u1_if.restart  = 1'b0;
    m1 = 7'h7F;
    acc1 = 0;
    while (acc1 < 5) u1_cycle(1'b1, 1'b0, 1'b0);
    check("rs5_cnt", u1_if.seq_cnt, 32'd5);
    u1_if.dout_rdy = 1'b1;
    u1_if.restart  = 1'b1;
    tick();
    u1_if.restart  = 1'b0;
    m1 = 7'h7F;
    acc1 = 0;
    repeat (3) u1_cycle(1'b1, 1'b0, 1'b0);

    // PRBS32 loopback into bench receiver with three injected errors
    rx_sh = '0;
    rx_n = 0;
    rx_err = 0;
    u7_if.en = 1'b1;
    u7_if.dout_rdy = 1'b1;
    tick();
    for (int i = 0; i < 200; i++) begin
      if (u7_if.dout_vld && u7_if.dout_rdy) begin
        b = u7_if.dout;
        if (rx_n < 32) begin
          rx_sh = {rx_sh[30:0], b};
          rx_n++;
        end else begin
          pred = rx_sh[31] ^ rx_sh[21] ^ rx_sh[1] ^ rx_sh[0];
          if (pred != b) rx_err++;
          rx_sh = {rx_sh[30:0], pred};
        end
      end
      u7_if.err_inj = (i == 50 || i == 90 || i == 130);
      tick();
      u7_if.err_inj = 1'b0;
    end
    check("lb_sync", rx_n, 32'd32);
    check("lb_inj", {16'd0, u7_if.inj_cnt}, 32'd3);
    check("lb_err", rx_err, {16'd0, u7_if.inj_cnt});

    // Reset mid-run
    u1_if.dout_rdy = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_vld", {31'd0, u1_if.dout_vld}, 32'd0);
    check("mr_dout", {31'd0, u1_if.dout}, 32'd0);
    check("mr_cnt", u1_if.seq_cnt, 32'd0);
    check("mr_inj", {16'd0, u7_if.inj_cnt}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs_tx.md
PRBS_TX -- requirements
Module: prbs_tx

Interface
REQ-001 The block SHALL have parameter PRBS_TYPE, default 7, which selects the polynomial (0..7) per REQ-012.
REQ-002 The block SHALL have parameter SEED, 32 bits, default 32'hFFFF_FFFF; it is the history-register load value and SHALL be nonzero in its low (order) bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port en, input, 1 bit: run request, level-sensitive.
REQ-006 The block SHALL have port restart, input, 1 bit: pulse that reloads SEED and clears seq_cnt.
REQ-007 The block SHALL have port err_inj, input, 1 bit: pulse that inverts the next accepted output bit.
REQ-008 The block SHALL have port dout_rdy, input, 1 bit: downstream ready.
REQ-009 The block SHALL have ports dout_vld (output, 1 bit) and dout (output, 1 bit): the serial PRBS bit and its valid.
REQ-010 The block SHALL have ports seq_cnt (output, 32 bits), the accepted-bit index within the period, and seq_wrap (output, 1 bit), a one-cycle period-complete pulse.
REQ-011 The block SHALL have port inj_cnt (output, 16 bits): count of injected errors, saturating.

Function
REQ-012 Taps SHALL be: 0:(2,0), 1:(6,0), 2:(8,4), 3:(10,8), 4:(14,0), 5:(16,2), 6:(22,17), 7:(31,21,1,0); the next bit equals the XOR of the selected history bits, with hist[0] being the most recent bit.
REQ-013 The period P SHALL be: 0:7, 1:127, 2:511, 3:2047, 4:32767, 5:131071, 6:8388607, 7:4294967295.
REQ-014 The FSM SHALL have states IDLE, RUN and STOP: IDLE->RUN when en=1; RUN->STOP when en=0; STOP->IDLE on handshake; STOP->RUN if en=1 again before the handshake.
REQ-015 dout_vld SHALL be 1 in RUN and STOP and 0 in IDLE; first valid is one cycle after en is sampled high in IDLE.
REQ-016 dout SHALL equal taps(hist) XOR inj_pend while dout_vld=1, and 0 otherwise.
REQ-017 A handshake (dout_vld&dout_rdy) SHALL shift the uninverted taps(hist) into hist[0], shift hist[31:1]<=hist[30:0], clear inj_pend, and advance seq_cnt.
REQ-018 With dout_vld=1 and dout_rdy=0, dout, hist and seq_cnt SHALL hold stable.
REQ-019 seq_cnt SHALL run 0..P-1; a handshake at P-1 SHALL set it to 0 and pulse seq_wrap in the next cycle.
REQ-020 err_inj SHALL set inj_pend and increment inj_cnt (saturating at 16'hFFFF); err_inj while inj_pend=1 SHALL be ignored and not counted.
REQ-021 restart SHALL load hist<=SEED and seq_cnt<=0, and SHALL clear inj_pend and seq_wrap in any state; it SHALL have priority over a simultaneous handshake, which is then discarded.
REQ-022 The FSM state SHALL be unchanged by restart.
REQ-023 In IDLE, hist and seq_cnt SHALL hold their values, so that resuming continues the sequence.

Reset
REQ-024 rst, sampled on the clk rising edge, SHALL force: state=IDLE, hist=SEED, seq_cnt=0, inj_pend=0, inj_cnt=0, seq_wrap=0, dout_vld=0, dout=0.
REQ-025 rst SHALL override all other inputs; reset mid-RUN SHALL drop dout_vld in the following cycle without completing a handshake.

Structure
REQ-026 The tap table, the period table and the PRBS_TYPE encoding SHALL reside in a shared package used by prbs_tx and the receiver.
REQ-027 The next-bit function SHALL be one sub-module, prbs_taps (combinational, hist in, bit out), reusable by the receiver.

Verification
REQ-028 The bench SHALL check: PRBS_TYPE=0, SEED=32'h7, rdy=1, en=1 -> dout 0,1,0,0,1,1,1 repeating; seq_wrap pulses after every 7th bit.
REQ-029 The bench SHALL check: PRBS_TYPE=1, rdy toggling randomly -> the accepted stream is identical to the rdy=1 stream; dout is stable while stalled.
REQ-030 The bench SHALL check: err_inj at accepted bit 10 -> only bit 10 is inverted, bit 11 onward is correct, and inj_cnt=1; a second err_inj while pending leaves inj_cnt=1.
REQ-031 The bench SHALL check: en dropped while rdy=0 -> dout_vld stays 1 until the handshake and then goes to 0; re-raising en resumes at the next sequence bit.
REQ-032 The bench SHALL check: restart coincident with a handshake at seq_cnt=5 -> seq_cnt=0 and the next bit is the first bit after SEED.
REQ-033 The bench SHALL check: loopback into the receiver with PRBS_TYPE=7 -> sync is achieved and the receiver error count equals inj_cnt.
